// File: rtl/u409_ata_pio_sequencer.sv
// u409_ata_pio_sequencer
//
// Shared ATA PIO cycle sequencer. Arbitrates between the primary (P) and
// secondary (S) channel requesters, then drives chip select, the DIOR/DIOW
// strobe and the read-data latch pulse with the PIO timing captured at grant.
// Returns a one-cycle completion pulse to the requester's transfer-ack logic.
// Timing table assumes a 40 MHz clock (25 ns per cycle).
//
// Ports
//   i_clk40            bus clock, rising edge
//   i_reset            synchronous, active-high reset
//   i_req_p/i_req_s    channel requests (level, held until ACK)
//   i_rnw              transfer direction (1 = read), captured at grant
//   i_mode_p/i_mode_s  PIO mode 0..4 per channel (5..7 behave as mode 0)
//   i_iordy            asynchronous drive ready, synchronised internally
//   o_sel_p/o_sel_s    channel select / buffer enable, active-high
//   o_diorn/o_diown    ATA read/write strobes, active-low
//   o_rdata_le         read-data latch pulse (reads only)
//   o_ack_p/o_ack_s    completion pulse, first RECOVER cycle
//   o_timeout          IORDY timeout flag, coincident with ACK
//   o_busy             high whenever the sequencer is not idle
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for a request; arbitration happens here
// SETUP   | select asserted, strobes inactive (t1 address setup)
// ACTIVE  | strobe asserted for t2, extended while IORDY is low
// RECOVER | strobe released, select held for address/CS hold + recovery

module u409_ata_pio_sequencer (
  input  logic       i_clk40,
  input  logic       i_reset,
  input  logic       i_req_p,
  input  logic       i_req_s,
  input  logic       i_rnw,
  input  logic [2:0] i_mode_p,
  input  logic [2:0] i_mode_s,
  input  logic       i_iordy,
  output logic       o_sel_p,
  output logic       o_sel_s,
  output logic       o_diorn,
  output logic       o_diown,
  output logic       o_rdata_le,
  output logic       o_ack_p,
  output logic       o_ack_s,
  output logic       o_timeout,
  output logic       o_busy
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETUP   = 2'd1,
    ST_ACTIVE  = 2'd2,
    ST_RECOVER = 2'd3
  } state_t;

  localparam logic       CH_P     = 1'b0;
  localparam logic       CH_S     = 1'b1;
  localparam logic [9:0] EXT_LAST = 10'd1023;

  // Counter load values are (cycles - 1) so the last cycle of a state is
  // the one where the counter reads zero.
  function automatic logic [4:0] f_setup_ld(input logic [2:0] mode);
    logic [4:0] ld;
    case (mode)
      3'd0:    ld = 5'd2;
      3'd1:    ld = 5'd1;
      3'd2:    ld = 5'd1;
      3'd3:    ld = 5'd1;
      3'd4:    ld = 5'd0;
      default: ld = 5'd2;
    endcase
    return ld;
  endfunction

  function automatic logic [4:0] f_active_ld(input logic [2:0] mode);
    logic [4:0] ld;
    case (mode)
      3'd0:    ld = 5'd6;
      3'd1:    ld = 5'd4;
      3'd2:    ld = 5'd3;
      3'd3:    ld = 5'd3;
      3'd4:    ld = 5'd2;
      default: ld = 5'd6;
    endcase
    return ld;
  endfunction

  function automatic logic [4:0] f_recover_ld(input logic [2:0] mode);
    logic [4:0] ld;
    case (mode)
      3'd0:    ld = 5'd13;
      3'd1:    ld = 5'd8;
      3'd2:    ld = 5'd3;
      3'd3:    ld = 5'd1;
      3'd4:    ld = 5'd0;
      default: ld = 5'd13;
    endcase
    return ld;
  endfunction

  // Sequencer state
  state_t     r_state;
  logic [4:0] r_cnt;
  logic [9:0] r_ext;
  logic       r_chan;
  logic       r_last;
  logic       r_rnw;
  logic [2:0] r_mode;
  logic       r_tmo;

  // IORDY synchroniser
  logic       r_iordy_s1;
  logic       r_iordy_s2;

  // Registered outputs
  logic       r_sel_p;
  logic       r_sel_s;
  logic       r_diorn;
  logic       r_diown;
  logic       r_rdata_le;
  logic       r_ack_p;
  logic       r_ack_s;
  logic       r_timeout;
  logic       r_busy;

  // Next-state values
  state_t     w_state_nxt;
  logic [4:0] w_cnt_nxt;
  logic [9:0] w_ext_nxt;
  logic       w_chan_nxt;
  logic       w_last_nxt;
  logic       w_rnw_nxt;
  logic [2:0] w_mode_nxt;
  logic       w_tmo_nxt;

  // Arbitration
  logic       w_grant_chan;
  logic [2:0] w_grant_raw;
  logic [2:0] w_grant_mode;

  // Next output values
  logic       w_active_exit;
  logic       w_busy_nxt;
  logic       w_strobe_nxt;
  logic       w_rdata_le_nxt;

  always_comb begin
    w_grant_chan = CH_P;
    if (i_req_p && i_req_s) begin
      w_grant_chan = ~r_last;
    end else if (i_req_s) begin
      w_grant_chan = CH_S;
    end
    w_grant_raw  = (w_grant_chan == CH_S) ? i_mode_s : i_mode_p;
    w_grant_mode = (w_grant_raw > 3'd4) ? 3'd0 : w_grant_raw;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_ext_nxt     = r_ext;
    w_chan_nxt    = r_chan;
    w_last_nxt    = r_last;
    w_rnw_nxt     = r_rnw;
    w_mode_nxt    = r_mode;
    w_tmo_nxt     = r_tmo;
    w_active_exit = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (i_req_p || i_req_s) begin
          w_state_nxt = ST_SETUP;
          w_cnt_nxt   = f_setup_ld(w_grant_mode);
          w_chan_nxt  = w_grant_chan;
          w_last_nxt  = w_grant_chan;
          w_rnw_nxt   = i_rnw;
          w_mode_nxt  = w_grant_mode;
          w_tmo_nxt   = 1'b0;
        end
      end

      ST_SETUP: begin
        if (r_cnt == 5'd0) begin
          w_state_nxt = ST_ACTIVE;
          w_cnt_nxt   = f_active_ld(r_mode);
          w_ext_nxt   = 10'd0;
        end else begin
          w_cnt_nxt = r_cnt - 5'd1;
        end
      end

      ST_ACTIVE: begin
        if (r_cnt != 5'd0) begin
          w_cnt_nxt = r_cnt - 5'd1;
        end else if (r_iordy_s2 || (r_ext == EXT_LAST)) begin
          // Leave on ready, or give up after the full extension budget.
          w_active_exit = 1'b1;
          w_state_nxt   = ST_RECOVER;
          w_cnt_nxt     = f_recover_ld(r_mode);
          w_tmo_nxt     = ~r_iordy_s2;
        end else begin
          w_ext_nxt = r_ext + 10'd1;
        end
      end

      ST_RECOVER: begin
        if (r_cnt == 5'd0) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = 5'd0;
          w_ext_nxt   = 10'd0;
        end else begin
          w_cnt_nxt = r_cnt - 5'd1;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = 5'd0;
        w_ext_nxt   = 10'd0;
      end
    endcase
  end

  // Outputs are registered from the next-state values, so they line up
  // with the state they describe. The read latch pulse must mark the cycle
  // in which ACTIVE will exit; the synchronised IORDY seen in that cycle is
  // what s1 holds now, which lets the pulse be registered too.
  always_comb begin
    w_busy_nxt     = (w_state_nxt != ST_IDLE);
    w_strobe_nxt   = (w_state_nxt == ST_ACTIVE);
    w_rdata_le_nxt = w_strobe_nxt && w_rnw_nxt && (w_cnt_nxt == 5'd0) &&
                     (r_iordy_s1 || (w_ext_nxt == EXT_LAST));
  end

  always_ff @(posedge i_clk40) begin
    if (i_reset) begin
      r_iordy_s1 <= 1'b0;
      r_iordy_s2 <= 1'b0;
    end else begin
      r_iordy_s1 <= i_iordy;
      r_iordy_s2 <= r_iordy_s1;
    end
  end

  always_ff @(posedge i_clk40) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= 5'd0;
      r_ext   <= 10'd0;
      r_chan  <= CH_P;
      r_last  <= CH_S;
      r_rnw   <= 1'b0;
      r_mode  <= 3'd0;
      r_tmo   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ext   <= w_ext_nxt;
      r_chan  <= w_chan_nxt;
      r_last  <= w_last_nxt;
      r_rnw   <= w_rnw_nxt;
      r_mode  <= w_mode_nxt;
      r_tmo   <= w_tmo_nxt;
    end
  end

  always_ff @(posedge i_clk40) begin
    if (i_reset) begin
      r_sel_p    <= 1'b0;
      r_sel_s    <= 1'b0;
      r_diorn    <= 1'b1;
      r_diown    <= 1'b1;
      r_rdata_le <= 1'b0;
      r_ack_p    <= 1'b0;
      r_ack_s    <= 1'b0;
      r_timeout  <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_sel_p    <= w_busy_nxt && (w_chan_nxt == CH_P);
      r_sel_s    <= w_busy_nxt && (w_chan_nxt == CH_S);
      r_diorn    <= ~(w_strobe_nxt && w_rnw_nxt);
      r_diown    <= ~(w_strobe_nxt && !w_rnw_nxt);
      r_rdata_le <= w_rdata_le_nxt;
      r_ack_p    <= w_active_exit && (r_chan == CH_P);
      r_ack_s    <= w_active_exit && (r_chan == CH_S);
      r_timeout  <= w_active_exit && w_tmo_nxt;
      r_busy     <= w_busy_nxt;
    end
  end

  assign o_sel_p    = r_sel_p;
  assign o_sel_s    = r_sel_s;
  assign o_diorn    = r_diorn;
  assign o_diown    = r_diown;
  assign o_rdata_le = r_rdata_le;
  assign o_ack_p    = r_ack_p;
  assign o_ack_s    = r_ack_s;
  assign o_timeout  = r_timeout;
  assign o_busy     = r_busy;

endmodule

// File: tb/tb_u409_ata_pio_sequencer.sv
// Bench for u409_ata_pio_sequencer. Requesters, direction, modes and IORDY
// are driven randomly; a transaction-level reference model predicts each
// cycle's outputs from the per-mode timing table and the IORDY sampling rule.

module tb_u409_ata_pio_sequencer;

  logic       clk = 1'b0;
  logic       reset, req_p, req_s, rnw, iordy;
  logic [2:0] mode_p, mode_s;
  logic       o_sel_p, o_sel_s, o_diorn, o_diown, o_rdata_le;
  logic       o_ack_p, o_ack_s, o_timeout, o_busy;

  always #10 clk = ~clk;

  u409_ata_pio_sequencer dut (
    .i_clk40   (clk),
    .i_reset   (reset),
    .i_req_p   (req_p),
    .i_req_s   (req_s),
    .i_rnw     (rnw),
    .i_mode_p  (mode_p),
    .i_mode_s  (mode_s),
    .i_iordy   (iordy),
    .o_sel_p   (o_sel_p),
    .o_sel_s   (o_sel_s),
    .o_diorn   (o_diorn),
    .o_diown   (o_diown),
    .o_rdata_le(o_rdata_le),
    .o_ack_p   (o_ack_p),
    .o_ack_s   (o_ack_s),
    .o_timeout (o_timeout),
    .o_busy    (o_busy)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // Reference model: one in-flight transaction described by its edge times.
  bit       m_act  = 1'b0;
  bit       m_chan = 1'b0;
  bit       m_rnw  = 1'b0;
  bit       m_last = 1'b1;
  bit       m_to   = 1'b0;
  int       m_g, m_fall, m_base, m_rise, m_idle, m_rec;
  bit [8:0] m_exp;

  // Stimulus controls
  int  req_pol   = 0;  // 0 none, 1 random, 2 always re-request mode 3
  int  iordy_pol = 2;  // 0 random low bursts, 1 stuck low, 2 high
  bit  rnw_rand  = 1'b1;
  bit  drop_p = 1'b0, drop_s = 1'b0;
  int  burst = 0;
  bit  cnt_en = 1'b0, ord_en = 1'b0;
  int  stuck_low = 0, tmo_cnt = 0;
  int  ack_q[$];

  task automatic mode_times(input logic [2:0] md, output int t1, output int t2, output int tr);
    case (md)
      3'd1:    begin t1 = 2; t2 = 5; tr = 9;  end
      3'd2:    begin t1 = 2; t2 = 4; tr = 4;  end
      3'd3:    begin t1 = 2; t2 = 4; tr = 2;  end
      3'd4:    begin t1 = 1; t2 = 3; tr = 1;  end
      default: begin t1 = 3; t2 = 7; tr = 14; end
    endcase
  endtask

  function automatic bit m_busy();
    return m_act && (m_rise < 0 || cyc < m_idle);
  endfunction

  task automatic step();
    logic [2:0] md;
    int  t1, t2, tr;
    bit  busy_e, strobe_e, rdle_e, ack_e, just_p, just_s;
    @(posedge clk);
    cyc++;
    busy_e = 0; strobe_e = 0; rdle_e = 0; ack_e = 0;
    if (reset) begin
      m_act  = 0;
      m_last = 1;
    end else begin
      if (m_act && m_rise >= 0 && cyc > m_idle) m_act = 0;
      if (!m_act && (req_p || req_s)) begin
        m_chan = (req_p && req_s) ? !m_last : req_s;
        m_last = m_chan;
        md     = m_chan ? mode_s : mode_p;
        mode_times(md, t1, t2, tr);
        m_rnw  = rnw;
        m_g    = cyc;
        m_fall = cyc + t1;
        m_base = cyc + t1 + t2 - 2;
        m_rise = -1;
        m_rec  = tr;
        m_act  = 1;
      end
      // IORDY sampled at this edge decides the exit two cycles later.
      if (m_act && m_rise < 0 && cyc >= m_base) begin
        if (iordy || (cyc - m_base) == 1023) begin
          m_rise = cyc + 2;
          m_to   = !iordy;
          m_idle = m_rise + m_rec;
        end
      end
      if (m_act) begin
        busy_e   = (m_rise < 0) || (cyc < m_idle);
        strobe_e = (cyc >= m_fall) && (m_rise < 0 || cyc < m_rise);
        rdle_e   = m_rnw && m_rise >= 0 && cyc == m_rise - 1;
        ack_e    = m_rise >= 0 && cyc == m_rise;
      end
    end
    m_exp = {busy_e & ~m_chan, busy_e & m_chan, ~(strobe_e & m_rnw),
             ~(strobe_e & ~m_rnw), rdle_e, ack_e & ~m_chan, ack_e & m_chan,
             ack_e & m_to, busy_e};

    #1;
    just_p = 0; just_s = 0;
    if (drop_p) begin req_p = 0; drop_p = 0; just_p = 1; end
    if (drop_s) begin req_s = 0; drop_s = 0; just_s = 1; end
    drop_p = m_exp[3];
    drop_s = m_exp[2];
    if (req_pol == 1) begin
      if (!req_p && !just_p && !drop_p && $urandom_range(0, 3) == 0) req_p = 1;
      else if (req_p && !drop_p && !(m_busy() && m_chan == 0) && $urandom_range(0, 15) == 0) req_p = 0;
      if (!req_s && !just_s && !drop_s && $urandom_range(0, 3) == 0) req_s = 1;
      else if (req_s && !drop_s && !(m_busy() && m_chan == 1) && $urandom_range(0, 15) == 0) req_s = 0;
      if ($urandom_range(0, 3) == 0) mode_p = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) mode_s = 3'($urandom_range(0, 7));
    end else if (req_pol == 2) begin
      if (!req_p && !just_p && !drop_p) begin req_p = 1; mode_p = 3'd3; end
      if (!req_s && !just_s && !drop_s) begin req_s = 1; mode_s = 3'd3; end
    end
    if (rnw_rand) rnw = 1'($urandom_range(0, 1));
    case (iordy_pol)
      0: begin
        if (burst > 0) begin iordy = 0; burst--; end
        else if ($urandom_range(0, 5) == 0) begin iordy = 0; burst = $urandom_range(0, 7); end
        else iordy = 1;
      end
      1: iordy = 0;
      default: iordy = 1;
    endcase

    @(negedge clk);
    chk("outs", 32'({o_sel_p, o_sel_s, o_diorn, o_diown, o_rdata_le,
                     o_ack_p, o_ack_s, o_timeout, o_busy}), 32'(m_exp));
    if (cnt_en) begin
      if (!o_diorn) stuck_low++;
      if (o_timeout) tmo_cnt++;
    end
    if (ord_en) begin
      if (o_ack_p) ack_q.push_back(0);
      if (o_ack_s) ack_q.push_back(1);
    end
  endtask

  task automatic drain();
    int n = 0;
    req_pol = 0;
    while ((req_p || req_s || m_busy()) && n < 400) begin
      step();
      n++;
    end
    chk("drain", 32'(n < 400), 32'd1);
  endtask

  initial begin
    reset = 1; req_p = 0; req_s = 0; rnw = 0; iordy = 1;
    mode_p = 3'd0; mode_s = 3'd0;
    repeat (3) step();
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_diorn", 32'(o_diorn), 32'd1);
    reset = 0;

    // Contention: both channels keep requesting, grants must alternate P,S,...
    ack_q.delete();
    ord_en = 1; req_pol = 2; iordy_pol = 2;
    repeat (45) step();
    ord_en = 0;
    chk("ack_count", 32'(ack_q.size() >= 4), 32'd1);
    for (int i = 0; i < 4; i++)
      chk("ack_order", (i < ack_q.size()) ? 32'(ack_q[i]) : 32'd2, 32'(i % 2));
    drain();

    // Random traffic with random IORDY low bursts and mode/direction churn.
    req_pol = 1; iordy_pol = 0; rnw_rand = 1;
    repeat (4000) step();
    iordy_pol = 2;
    drain();

    // IORDY stuck low on a mode 4 read.
    rnw_rand = 0; rnw = 1; req_p = 1; mode_p = 3'd4;
    iordy_pol = 1; iordy = 0;
    stuck_low = 0; tmo_cnt = 0; cnt_en = 1;
    repeat (1100) step();
    iordy_pol = 2;
    repeat (30) step();
    cnt_en = 0;
    chk("stuck_low_len", 32'(stuck_low), 32'd1026);
    chk("stuck_timeout", 32'(tmo_cnt), 32'd1);
    drain();
    req_p = 1; mode_p = 3'd4; rnw = 0;
    repeat (12) step();
    drain();

    // Reset in the middle of a mode 1 write on S.
    req_s = 1; mode_s = 3'd1; rnw = 0;
    repeat (4) step();
    reset = 1; req_p = 1; mode_p = 3'd3; mode_s = 3'd3;
    step();
    chk("midrst_diown", 32'(o_diown), 32'd1);
    chk("midrst_sel_s", 32'(o_sel_s), 32'd0);
    chk("midrst_ack_s", 32'(o_ack_s), 32'd0);
    reset = 0;
    ack_q.delete();
    ord_en = 1;
    repeat (30) step();
    ord_en = 0;
    chk("post_rst_first", (ack_q.size() > 0) ? 32'(ack_q[0]) : 32'd2, 32'd0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
